// File: rtl/gate_bank_reg.sv
// Registered mode-selected bitwise gate (OR/AND/XOR/XNOR) with a valid/ready
// output channel and one holding register per mode for accumulate chaining.
module gate_bank_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       out_mode,
  output logic             y_zero,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] s
);

  localparam int unsigned NMODES = 4;

  logic [NMODES-1:0][WIDTH-1:0] held;
  logic                         accept_c;
  logic [WIDTH-1:0]             a_eff_c;
  logic [WIDTH-1:0]             res_c;

  // A slot frees up either when empty or when the consumer drains it this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // A same-cycle clear wins over the held value, so accumulate then starts from zero.
  always_comb begin
    a_eff_c = a;
    if (acc) begin
      a_eff_c = clr ? '0 : held[m];
    end
    res_c = '0;
    case (m)
      2'b00:   res_c = a_eff_c | b;
      2'b01:   res_c = a_eff_c & b;
      2'b10:   res_c = a_eff_c ^ b;
      default: res_c = ~(a_eff_c ^ b);
    endcase
  end

  // Output channel register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      out_mode  <= 2'b00;
      y_zero    <= 1'b1;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      y         <= res_c;
      out_mode  <= m;
      y_zero    <= ~|res_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Per-mode holding registers; the written mode takes the result, clear zeroes the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
    end else begin
      for (int unsigned i = 0; i < NMODES; i++) begin
        if (accept_c && (m == 2'(i))) begin
          held[i] <= res_c;
        end else if (clr) begin
          held[i] <= '0;
        end
      end
    end
  end

  assign p = held[0];
  assign q = held[1];
  assign r = held[2];
  assign s = held[3];

endmodule

// File: tb/tb_gate_bank_reg.sv
// Bench for gate_bank_reg: directed scenarios then random traffic, all checked
// against a transaction-level reference model.
module tb_gate_bank_reg;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [1:0]       out_mode;
  logic             y_zero;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] s;

  gate_bank_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .m(m), .a(a), .b(b), .acc(acc), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_mode(out_mode), .y_zero(y_zero),
    .p(p), .q(q), .r(r), .s(s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mh [4];
  logic [7:0] my;
  logic [1:0] mmode;
  logic       mv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gate_op(input logic [1:0] mode, input logic [7:0] x, input logic [7:0] z);
    case (mode)
      2'd0:    return x | z;
      2'd1:    return x & z;
      2'd2:    return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mh[i] = 8'h00;
    my = 8'h00; mmode = 2'b00; mv = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mv));
    check({tag, ".y"},         32'(y),         32'(my));
    check({tag, ".out_mode"},  32'(out_mode),  32'(mmode));
    check({tag, ".y_zero"},    32'(y_zero),    32'(my == 8'h00));
    check({tag, ".p"},         32'(p),         32'(mh[0]));
    check({tag, ".q"},         32'(q),         32'(mh[1]));
    check({tag, ".r"},         32'(r),         32'(mh[2]));
    check({tag, ".s"},         32'(s),         32'(mh[3]));
  endtask

  // Called at a falling edge; drives one cycle, advances model, checks after the edge.
  task automatic drive(input string tag, input logic iv, input logic [1:0] mm,
                       input logic [7:0] aa, input logic [7:0] bb,
                       input logic ac, input logic cl, input logic ordy);
    logic       exp_ready;
    logic       take;
    logic [7:0] aeff;
    logic [7:0] res;
    in_valid = iv; m = mm; a = aa; b = bb; acc = ac; clr = cl; out_ready = ordy;
    #1;
    exp_ready = !mv || ordy;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    take = iv && exp_ready;
    if (cl) for (int i = 0; i < 4; i++) mh[i] = 8'h00;
    if (take) begin
      aeff = ac ? mh[mm] : aa;
      res = gate_op(mm, aeff, bb);
      mh[mm] = res;
      my = res; mmode = mm; mv = 1'b1;
    end else if (ordy) begin
      mv = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; m = 2'b00; a = '0; b = '0;
    acc = 1'b0; clr = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);

    // OR
    drive("or", 1'b1, 2'd0, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1);
    check("or.y_lit", 32'(y), 32'h0000_00FF);

    // XOR accumulate; operand a is ignored
    drive("xacc1", 1'b1, 2'd2, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
    check("xacc1.r_lit", 32'(r), 32'h0000_0055);
    drive("xacc2", 1'b1, 2'd2, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
    check("xacc2.y_zero_lit", 32'(y_zero), 32'(1));

    // XNOR / AND mix
    drive("xnor1", 1'b1, 2'd3, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b1);
    check("xnor1.s_lit", 32'(s), 32'h0000_00FF);
    drive("and1",  1'b1, 2'd1, 8'hAA, 8'h0F, 1'b0, 1'b0, 1'b1);
    check("and1.q_lit", 32'(q), 32'h0000_000A);
    drive("xnor2", 1'b1, 2'd3, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    check("xnor2.s_lit", 32'(s), 32'h0000_0000);

    // Back-pressure
    drive("bp_acc", 1'b1, 2'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive("bp_hold", 1'b1, 2'd1, 8'hAA, 8'h0F, 1'b0, 1'b0, 1'b0);
      check("bp_hold.y_lit", 32'(y), 32'h0000_0003);
    end
    drive("bp_rel", 1'b1, 2'd1, 8'hAA, 8'h0F, 1'b0, 1'b0, 1'b1);
    check("bp_rel.y_lit", 32'(y), 32'h0000_000A);

    // Clear together with an accumulate accept
    drive("setp", 1'b1, 2'd0, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1);
    drive("sets", 1'b1, 2'd3, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b1);
    drive("clracc", 1'b1, 2'd2, 8'hAA, 8'h3C, 1'b1, 1'b1, 1'b1);
    check("clracc.y_lit", 32'(y), 32'h0000_003C);
    check("clracc.p_lit", 32'(p), 32'h0000_0000);

    // Drain, then clear without accept leaves the channel alone
    drive("drain", 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    drive("fill",  1'b1, 2'd2, 8'h0F, 8'h33, 1'b0, 1'b0, 1'b0);
    drive("clr_only", 1'b0, 2'd1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);

    // Reset mid-stream with a pending result
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    check("midrst.no_spurious", 32'(out_valid), 32'(0));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive("rand", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_bank_reg.md
# gate_bank_reg

Registered, parametrised successor to the team's mode-selected gate unit. Applies one of four bitwise operations (OR, AND, XOR, XNOR), chosen per transaction by a 2-bit mode, to WIDTH-bit operands. Each result is written both to a handshaked output channel and to a per-mode holding register. An accumulate option chains an operation onto that mode's previous result. Sits between an operand producer and a result consumer, both using valid/ready.

## Interface
- WIDTH, 8, operand/result bit width (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  block can accept a transaction this cycle
- m  in  2  mode: 00 OR, 01 AND, 10 XOR, 11 XNOR
- a  in  WIDTH  operand A (ignored when acc=1)
- b  in  WIDTH  operand B
- acc  in  1  accumulate: operand A := current holding register of mode m
- clr  in  1  synchronous clear of all four holding registers
- out_valid  out  1  y/out_mode/y_zero hold a valid result
- out_ready  in  1  consumer takes result this cycle
- y  out  WIDTH  result of last accepted transaction
- out_mode  out  2  mode of the result on y
- y_zero  out  1  y == 0
- p, q, r, s  out  WIDTH each  holding registers for OR, AND, XOR, XNOR results

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational; there is no path from in_valid to in_ready.
- On accept:
  - a_eff = acc ? held[m] : a, where held = {p,q,r,s} indexed by m.
  - res = a_eff|b, a_eff&b, a_eff^b or ~(a_eff^b), selected by m.
  - Register y=res, out_mode=m, y_zero=(res==0), out_valid=1.
  - Write held[m]=res. The other three holding registers keep their values.
- No accept and out_ready=1: out_valid←0. y, out_mode and y_zero keep their last values.
- No accept and out_ready=0: all outputs hold.
- clr=1 without accept: p,q,r,s←0. The output channel is unaffected.
- clr=1 with accept:
  - The clear applies first, so a_eff uses 0 when acc=1.
  - held[m]←res; the other three holding registers ←0.
  - y and out_valid update normally.
- m, a, b, acc and clr are sampled only at the clock edge. Values of m, a, b and acc outside accept cycles have no effect.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - out_valid=0, y=0, out_mode=00, y_zero=1, p=q=r=s=0.
  - in_ready=1 while rst is deasserted and out_valid=0.
- Latency: 1 cycle. A result accepted at edge N is visible on y and held[m] after edge N.
- Throughput: 1 transaction/cycle when out_ready=1.
- Back-to-back accumulate on the same mode sees the result written at the previous edge; no bubble.
- Back-pressure: while out_valid=1 and out_ready=0, in_ready=0, and y, out_mode, y_zero are stable. The producer must hold in_valid and its data stable until accepted.
- Simultaneous consume and accept: the old result leaves, the new result loads, and out_valid stays 1.
- Reset mid-transaction: the pending result is discarded. Deasserting rst creates no spurious out_valid.
- Width rules: all operations are bitwise on WIDTH bits, with no carry or overflow. y_zero is the NOR-reduce of res.

## Test plan
WIDTH=8 for all scenarios.
- Reset: assert rst mid-stream with out_valid=1 → outputs zero immediately, y_zero=1, out_valid=0. After deassert → in_ready=1.
- OR: m=00, a=F0, b=0F, accept → next cycle y=FF, out_mode=00, p=FF, y_zero=0, q=r=s=00.
- XOR accumulate from r=00:
  - acc=1, m=10, b=55 → y=55, r=55.
  - Next cycle acc=1, b=55 → y=00, r=00, y_zero=1.
  - a is driven to AA throughout and has no effect.
- XNOR/AND mix:
  - m=11, a=AA, b=AA → s=FF.
  - m=01, a=AA, b=0F → q=0A.
  - m=11, a=AA, b=55 → s=00, q stays 0A.
- Back-pressure: accept m=00, a=01, b=02 (y=03), then hold out_ready=0 for 3 cycles with in_valid=1, m=01 → in_ready=0 and y=03 stable. Raise out_ready → accept that cycle, next cycle y=AND result.
- clr with accept: p=FF, q=0A, s=FF; then clr=1, acc=1, m=10, b=3C → y=3C, r=3C, p=q=s=00.
